// File: rtl/serial_arith_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract unit.
package serial_arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int ndig_f(int width, int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit.
  function automatic int cnt_w_f(int width, int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok_f(int width, int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple full-adder chain used once per clock by the serial unit.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement add/subtract: DIGIT bits per clock, LSB first,
// with start/busy/done handshake and registered sum/carry/overflow/zero.
module serial_addsub_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = ndig_f(WIDTH, DIGIT);
  localparam int CW   = cnt_w_f(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!params_ok_f(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_addsub_unit: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, carry_q, ovf_q, zero_q;
  logic [WIDTH-1:0] sum_q;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_cmsb;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a       (a_q[DIGIT-1:0]),
    .b       (b_q[DIGIT-1:0]),
    .cin     (c_q),
    .s       (dig_s),
    .cout    (dig_cout),
    .c_msb_in(dig_cmsb)
  );

  // New result digits enter from the MSB side so the last digit lands the sum in place.
  assign res_d = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign a_d   = a_q >> DIGIT;
  assign b_d   = b_q >> DIGIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          res_q <= res_d;
          c_q   <= dig_cout;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            carry_q <= dig_cout;
            ovf_q   <= dig_cmsb ^ dig_cout;
            zero_q  <= (res_d == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; subtraction is A + ~B + 1.
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            c_q     <= sub;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
